spi_memory_core: RTL and testbench
==================================

# spi_memory_core

Frame-level SPI slave engine with an on-chip register-file memory. Sits directly downstream of the input conditioners: it consumes the conditioned chip-select and MOSI levels and the one-cycle SCLK edge pulses they produce, decodes an address/R-W byte, then writes a data byte or serially returns one on MISO. All logic runs in the system clock domain; SCLK is never used as a clock.

## Interface
- ADDR_WIDTH, 7, address bits; memory depth 2^ADDR_WIDTH; command byte = ADDR_WIDTH address bits + 1 R/W bit
- DATA_WIDTH, 8, data word and data-phase bit count
- clk  in  1  system clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- cs_n  in  1  conditioned chip select level; low = frame active
- mosi  in  1  conditioned serial data in
- sclk_posedge  in  1  one-clk pulse per SCLK rising edge
- sclk_negedge  in  1  one-clk pulse per SCLK falling edge
- miso  out  1  serial data out; MSB of output shift register
- miso_en  out  1  high only while read data is being driven (tri-state enable for pad)
- frame_done  out  1  one-clk pulse on completion of a full read or write frame

## Operation
- States: IDLE, GET_CMD, READ_LOAD, READ, WRITE, WRITE_COMMIT, DONE.
- IDLE: cs_n low -> GET_CMD, bit counter cleared.
- GET_CMD: on each sclk_posedge shift mosi into command register, MSB first; after ADDR_WIDTH+1 samples latch address, last bit = R/W (1 = read). Read -> READ_LOAD, write -> WRITE.
- READ_LOAD: one clk; load out-shift register from mem[addr]; miso_en = 1; -> READ.
- READ: count sclk_posedge (master samples); shift out-register left on sclk_negedge only after ≥1 data posedge in this phase; after DATA_WIDTH posedges -> DONE with frame_done pulse, miso_en = 0.
- WRITE: shift mosi in on sclk_posedge; after DATA_WIDTH samples -> WRITE_COMMIT.
- WRITE_COMMIT: one clk; mem[addr] <= data; frame_done pulse; -> DONE.
- DONE: ignore all SCLK pulses; wait for cs_n high -> IDLE.
- cs_n high in any state: next clk -> IDLE, miso_en = 0, counters cleared, partial write discarded (memory untouched), no frame_done.
- sclk_posedge and sclk_negedge both high in one cycle: illegal; posedge action taken, negedge ignored.
- SCLK pulses while in IDLE (cs_n high) have no effect.
- Address wraps only by width; no range checking.

## Timing
- Reset (async assert): state IDLE, miso 0, miso_en 0, frame_done 0, counters 0, shift registers 0, all memory words 0x00. Deassertion takes effect on next clk.
- Reset mid-frame: same as above, memory cleared; frame abandoned.
- Command decode latency: READ_LOAD entered 1 clk after final command sclk_posedge; miso valid with MSB and miso_en = 1 one clk later (2 clk after that edge), well before the next SCLK rise at any legal SCLK rate.
- SCLK period must be ≥ 4 clk per half-period (guaranteed by conditioner debounce); behaviour for faster SCLK undefined.
- Write commit: memory updated 2 clk after final data sclk_posedge; frame_done asserted in the same cycle as the commit.
- Read completion: frame_done asserted 1 clk after final data sclk_posedge.
- frame_done width exactly one clk; never asserted for aborted frames.
- miso holds its value between sclk_negedge pulses; returns to 0 when miso_en drops.

## Test plan
- Write frame cmd 0x24 (addr 0x12, W) + data 0xA5, then read frame cmd 0x25 -> miso bits 1,0,1,0,0,1,0,1 at successive sclk rises, miso_en high exactly during data phase, one frame_done per frame.
- Read of never-written addr 0x7F (cmd 0xFF) after reset -> eight 0 bits, frame_done pulse.
- Write to addr 0x03 with cs_n raised after 5 data bits, then read 0x03 -> 0x00, no frame_done on aborted frame.
- reset_n pulsed low mid-read -> miso_en and miso drop immediately (async), state IDLE, prior written 0xA5 at 0x12 reads back 0x00.
- 20 SCLK edge pulses with cs_n high, then valid write 0x5A to 0x01 and readback -> 0x5A, no spurious writes elsewhere (read 0x00 returns 0x00).
- Extra SCLK pulses after a completed write while cs_n still low -> no second commit, no frame_done, memory unchanged until cs_n toggles.

Source files
------------

// File: rtl/spi_memory_core_if.sv
// spi_memory_core_if: conditioned SPI levels/edge pulses in, MISO and frame status out
interface spi_memory_core_if;
  logic cs_n;
  logic mosi;
  logic sclk_posedge;
  logic sclk_negedge;
  logic miso;
  logic miso_en;
  logic frame_done;
  modport master (
    output cs_n, mosi, sclk_posedge, sclk_negedge,
    input  miso, miso_en, frame_done
  );
  modport slave (
    input  cs_n, mosi, sclk_posedge, sclk_negedge,
    output miso, miso_en, frame_done
  );
endinterface

// File: rtl/spi_memory_core.sv
// spi_memory_core: SPI slave frame engine (command byte + one data byte) over a register-file memory
module spi_memory_core #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  spi_memory_core_if.slave   bus
);
  localparam int MAXB = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int CW = $clog2(MAXB + 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(ADDR_WIDTH);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, GET_CMD, READ_LOAD, READ, WRITE, WRITE_COMMIT, DONE} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] cmd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] out_sr;
  logic [DATA_WIDTH-1:0] in_sr;
  logic [CW-1:0]         cnt;
  logic                  drive;
  logic                  done_pulse;
  assign bus.miso       = out_sr[DATA_WIDTH-1];
  assign bus.miso_en    = drive;
  assign bus.frame_done = done_pulse;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmd        <= '0;
      addr       <= '0;
      out_sr     <= '0;
      in_sr      <= '0;
      cnt        <= '0;
      drive      <= 1'b0;
      done_pulse <= 1'b0;
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
    end else begin
      done_pulse <= 1'b0;
      // chip select release aborts whatever is in flight, including a pending commit
      if (bus.cs_n) begin
        state  <= IDLE;
        cnt    <= '0;
        drive  <= 1'b0;
        out_sr <= '0;
        in_sr  <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= GET_CMD;
            cnt   <= '0;
          end
          GET_CMD: if (bus.sclk_posedge) begin
            cmd <= {cmd[ADDR_WIDTH-2:0], bus.mosi};
            cnt <= cnt + 1'b1;
            if (cnt == CMD_LAST) begin
              addr  <= cmd;
              cnt   <= '0;
              state <= bus.mosi ? READ_LOAD : WRITE;
            end
          end
          READ_LOAD: begin
            out_sr <= mem[addr];
            drive  <= 1'b1;
            state  <= READ;
          end
          // MSB is presented before the first data rise; later bits advance on falls after a sample
          READ: if (bus.sclk_posedge) begin
            cnt <= cnt + 1'b1;
            if (cnt == DATA_LAST) begin
              cnt        <= '0;
              drive      <= 1'b0;
              out_sr     <= '0;
              done_pulse <= 1'b1;
              state      <= DONE;
            end
          end else if (bus.sclk_negedge && cnt != '0) begin
            out_sr <= out_sr << 1;
          end
          WRITE: if (bus.sclk_posedge) begin
            in_sr <= {in_sr[DATA_WIDTH-2:0], bus.mosi};
            cnt   <= cnt + 1'b1;
            if (cnt == DATA_LAST) begin
              cnt   <= '0;
              state <= WRITE_COMMIT;
            end
          end
          WRITE_COMMIT: begin
            mem[addr]  <= in_sr;
            done_pulse <= 1'b1;
            state      <= DONE;
          end
          DONE: state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_memory_core.sv
// tb_spi_memory_core: table-driven frame vectors plus hand sequences for abort, reset and stray SCLK cases
module tb_spi_memory_core;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  spi_memory_core_if bus();
  spi_memory_core dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  typedef struct {
    logic [7:0] cmd;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[10];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output logic [7:0] en);
    rx = '0;
    en = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.mosi = tx[i];
      repeat (3) @(negedge clk);
      rx[i] = bus.miso;
      en[i] = bus.miso_en;
      bus.sclk_posedge = 1'b1;
      @(negedge clk);
      bus.sclk_posedge = 1'b0;
      repeat (3) @(negedge clk);
      bus.sclk_negedge = 1'b1;
      @(negedge clk);
      bus.sclk_negedge = 1'b0;
    end
  endtask
  task automatic begin_frame();
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic end_frame();
    bus.cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] wd, output logic [7:0] rd,
                           output logic [7:0] en_cmd, output logic [7:0] en_data, output int fdd);
    int f0;
    logic [7:0] dummy;
    begin_frame();
    f0 = fd_cnt;
    xfer_bits(cmd, 8, dummy, en_cmd);
    xfer_bits(wd, 8, rd, en_data);
    repeat (3) @(negedge clk);
    fdd = fd_cnt - f0;
    end_frame();
  endtask
  task automatic read_byte(input logic [7:0] cmd, output logic [7:0] rd, output int fdd);
    logic [7:0] ec, ed;
    run_frame(cmd, 8'h00, rd, ec, ed, fdd);
  endtask
  initial begin
    logic [7:0] rd, ec, ed, dummy;
    int fdd, f0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.sclk_posedge = 1'b0;
    bus.sclk_negedge = 1'b0;
    tbl[0] = '{8'hFF, 8'h00, 8'h00};
    tbl[1] = '{8'h24, 8'hA5, 8'h00};
    tbl[2] = '{8'h25, 8'h00, 8'hA5};
    tbl[3] = '{8'h02, 8'h5A, 8'h00};
    tbl[4] = '{8'h03, 8'h00, 8'h5A};
    tbl[5] = '{8'h01, 8'h00, 8'h00};
    tbl[6] = '{8'hFE, 8'h3C, 8'h00};
    tbl[7] = '{8'hFF, 8'h00, 8'h3C};
    tbl[8] = '{8'h00, 8'hFF, 8'h00};
    tbl[9] = '{8'h01, 8'h00, 8'hFF};
    repeat (3) @(negedge clk);
    check("reset miso", 32'(bus.miso), 0);
    check("reset miso_en", 32'(bus.miso_en), 0);
    check("reset frame_done", 32'(bus.frame_done), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      run_frame(tbl[k].cmd, tbl[k].wdata, rd, ec, ed, fdd);
      if (tbl[k].cmd[0]) check($sformatf("vec%0d read data", k), 32'(rd), 32'(tbl[k].exp));
      check($sformatf("vec%0d miso_en data phase", k), 32'(ed), tbl[k].cmd[0] ? 32'hFF : 32'h00);
      check($sformatf("vec%0d miso_en cmd phase", k), 32'(ec), 0);
      check($sformatf("vec%0d frame_done count", k), 32'(fdd), 1);
      check($sformatf("vec%0d miso_en idle", k), 32'(bus.miso_en), 0);
    end
    // aborted write: cs_n raised after 5 data bits
    begin_frame();
    f0 = fd_cnt;
    xfer_bits(8'h06, 8, dummy, ec);
    xfer_bits(8'hFF, 5, dummy, ed);
    repeat (3) @(negedge clk);
    end_frame();
    check("abort frame_done", 32'(fd_cnt - f0), 0);
    read_byte(8'h07, rd, fdd);
    check("abort mem untouched", 32'(rd), 0);
    // async reset in the middle of a read of 0x12 (holds 0xA5)
    begin_frame();
    xfer_bits(8'h25, 8, dummy, ec);
    xfer_bits(8'h00, 3, rd, ed);
    check("mid-read partial bits", 32'(rd[7:5]), 32'h5);
    check("mid-read miso_en", 32'(bus.miso_en), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset miso_en", 32'(bus.miso_en), 0);
    check("async reset miso", 32'(bus.miso), 0);
    bus.cs_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    read_byte(8'h25, rd, fdd);
    check("reset cleared 0x12", 32'(rd), 0);
    check("reset read frame_done", 32'(fdd), 1);
    read_byte(8'hFF, rd, fdd);
    check("reset cleared 0x7F", 32'(rd), 0);
    // stray SCLK pulses with cs_n high
    f0 = fd_cnt;
    for (int i = 0; i < 20; i++) begin
      bus.mosi = i[0];
      bus.sclk_posedge = ~i[1];
      bus.sclk_negedge = i[1];
      @(negedge clk);
      bus.sclk_posedge = 1'b0;
      bus.sclk_negedge = 1'b0;
      @(negedge clk);
    end
    check("stray sclk frame_done", 32'(fd_cnt - f0), 0);
    run_frame(8'h02, 8'h5A, rd, ec, ed, fdd);
    check("post-stray write frame_done", 32'(fdd), 1);
    read_byte(8'h03, rd, fdd);
    check("post-stray readback 0x01", 32'(rd), 32'h5A);
    read_byte(8'h01, rd, fdd);
    check("post-stray 0x00 clean", 32'(rd), 0);
    // extra SCLK after completed write while cs_n stays low
    begin_frame();
    f0 = fd_cnt;
    xfer_bits(8'h0A, 8, dummy, ec);
    xfer_bits(8'h11, 8, dummy, ed);
    repeat (3) @(negedge clk);
    check("write frame_done before extra", 32'(fd_cnt - f0), 1);
    xfer_bits(8'hEE, 8, dummy, ed);
    xfer_bits(8'h0B, 8, dummy, ed);
    repeat (3) @(negedge clk);
    check("extra sclk no frame_done", 32'(fd_cnt - f0), 1);
    check("extra sclk miso_en", 32'(ed), 0);
    end_frame();
    read_byte(8'h0B, rd, fdd);
    check("extra sclk mem unchanged", 32'(rd), 32'h11);
    read_byte(8'h77, rd, fdd);
    check("extra sclk no write to 0x3B", 32'(rd), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
